// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, latencies and decode helpers for the MD unit; MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU
package mdu_pkg;
    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;
    typedef enum logic [3:0] {
        MDU_NOP   = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10,
        MDU_MSUB  = 4'd11,
        MDU_MSUBU = 4'd12
    } mdu_op_e;
    typedef enum logic [1:0] {WR_NONE, WR_SET, WR_ADD, WR_SUB} mdu_wr_e;
    typedef enum logic {ST_IDLE, ST_BUSY} mdu_state_e;
    function automatic logic is_div(input logic [3:0] op);
        return op == MDU_DIV || op == MDU_DIVU;
    endfunction
    function automatic logic is_acc(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return op inside {MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
`else
        return 1'b0;
`endif
    endfunction
    function automatic logic is_muldiv(input logic [3:0] op);
        return op == MDU_MULT || op == MDU_MULTU || is_div(op) || is_acc(op);
    endfunction
endpackage

// File: rtl/mdu_if.sv
// mdu_if: E-stage MD instruction request and HI/LO/stall response bundle
interface mdu_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        d_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;
    modport master (output start, op, rs, rt, d_md, input busy, stall, hi, lo, rd_data);
    modport slave  (input start, op, rs, rt, d_md, output busy, stall, hi, lo, rd_data);
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit {hi,lo} result for mul/div ops (product for accumulate ops)
module mdu_arith import mdu_pkg::*; (
    input  logic [3:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output logic [63:0] res_o
);
    logic        sgn;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] qm;
    logic [31:0] rm;
    logic [63:0] prod;
    // divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow
    always_comb begin
        sgn   = op_i inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB};
        neg_a = sgn & rs_i[31];
        neg_b = sgn & rt_i[31];
        prod  = {{32{neg_a}}, rs_i} * {{32{neg_b}}, rt_i};
        abs_a = neg_a ? -rs_i : rs_i;
        abs_b = neg_b ? -rt_i : rt_i;
        qm    = abs_a / (abs_b == '0 ? 32'd1 : abs_b);
        rm    = abs_a % (abs_b == '0 ? 32'd1 : abs_b);
        res_o = is_div(op_i) ? {neg_a ? -rm : rm, (neg_a ^ neg_b) ? -qm : qm} : prod;
    end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MD unit sequencer (IDLE/BUSY FSM, busy counter, HI/LO, D-stage stall); MDU_MADD_EN adds accumulate ops
module mdu_ctrl import mdu_pkg::*; #(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input logic   clk,
    input logic   reset,
    mdu_if.slave  md
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    mdu_state_e  state_q, state_d;
    mdu_wr_e     wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] pend_q, pend_d;
    logic [63:0] res;
    logic [63:0] acc;

    mdu_arith u_arith (.op_i(md.op), .rs_i(md.rs), .rt_i(md.rt), .res_o(res));

    assign acc        = {hi_q, lo_q};
    assign md.busy    = state_q == ST_BUSY;
    assign md.stall   = reset & md.d_md & (md.busy | (md.start & is_muldiv(md.op)));
    assign md.hi      = hi_q;
    assign md.lo      = lo_q;
    assign md.rd_data = md.op == MDU_MFHI ? hi_q : md.op == MDU_MFLO ? lo_q : '0;

    // next state: launch in IDLE, count down in BUSY, commit pending result on the last busy edge
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        if (state_q == ST_IDLE && md.start) begin
            if (is_muldiv(md.op)) begin
                state_d = ST_BUSY;
                cnt_d   = is_div(md.op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                pend_d  = res;
                wr_d    = (is_div(md.op) && md.rt == '0) ? WR_NONE :
                          md.op inside {MDU_MADD, MDU_MADDU} ? WR_ADD :
                          md.op inside {MDU_MSUB, MDU_MSUBU} ? WR_SUB : WR_SET;
            end
            hi_d = md.op == MDU_MTHI ? md.rs : hi_q;
            lo_d = md.op == MDU_MTLO ? md.rs : lo_q;
        end else if (state_q == ST_BUSY) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                state_d      = ST_IDLE;
                {hi_d, lo_d} = wr_q == WR_SET ? pend_q :
                               wr_q == WR_ADD ? acc + pend_q :
                               wr_q == WR_SUB ? acc - pend_q : acc;
            end
        end
    end

    // state registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wr_q    <= WR_NONE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: randomized bench for mdu_ctrl against a transaction-level HI/LO model
module tb_mdu_ctrl;
    import mdu_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_if bus();
    mdu_ctrl dut (.clk(clk), .reset(rst_n), .md(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int lat(input logic [3:0] o);
        if (o == MDU_MULT || o == MDU_MULTU) return 5;
        if (o == MDU_DIV || o == MDU_DIVU) return 10;
`ifdef MDU_MADD_EN
        if (o >= MDU_MADD && o <= MDU_MSUBU) return 5;
`endif
        return 0;
    endfunction

    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, acc;
        logic [63:0]     q, r;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        acc = {m_hi, m_lo};
        case (o)
            MDU_MULT:  {m_hi, m_lo} = sa * sb;
            MDU_MULTU: {m_hi, m_lo} = ua * ub;
            MDU_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
            MDU_DIVU:  if (b != 0) begin q = ua / ub; r = ua % ub; m_lo = q[31:0]; m_hi = r[31:0]; end
            MDU_MTHI:  m_hi = a;
            MDU_MTLO:  m_lo = a;
`ifdef MDU_MADD_EN
            MDU_MADD:  {m_hi, m_lo} = acc + sa * sb;
            MDU_MADDU: {m_hi, m_lo} = acc + ua * ub;
            MDU_MSUB:  {m_hi, m_lo} = acc - sa * sb;
            MDU_MSUBU: {m_hi, m_lo} = acc - ua * ub;
`endif
            default: ;
        endcase
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit dm_fix);
        int          n, r;
        logic        dm;
        logic [31:0] ohi, olo;
        n   = lat(o);
        ohi = m_hi;
        olo = m_lo;
        @(negedge clk);
        dm = dm_fix | 1'($urandom_range(0, 1));
        bus.start = 1'b1;
        bus.op    = o;
        bus.rs    = a;
        bus.rt    = b;
        bus.d_md  = dm;
        #1;
        check("stall_issue", bus.stall, dm & (n > 0));
        check("rd_issue", bus.rd_data, o == MDU_MFHI ? ohi : o == MDU_MFLO ? olo : 32'h0);
        model(o, a, b);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            r = $urandom_range(0, 2);
            dm = dm_fix | 1'($urandom_range(0, 1));
            bus.start = 1'b0;
            bus.d_md  = dm;
            bus.op    = r == 0 ? MDU_MFHI : r == 1 ? MDU_MFLO : MDU_NOP;
            #1;
            check("busy", bus.busy, 1'b1);
            check("stall_busy", bus.stall, dm);
            check("rd_busy", bus.rd_data, r == 0 ? ohi : r == 1 ? olo : 32'h0);
            check("hilo_busy", {bus.hi, bus.lo}, {ohi, olo});
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = MDU_MFLO;
        bus.d_md  = dm;
        #1;
        check("busy_done", bus.busy, 1'b0);
        check("stall_done", bus.stall, 1'b0);
        check("hi", bus.hi, m_hi);
        check("lo", bus.lo, m_lo);
        check("rd_lo", bus.rd_data, m_lo);
    endtask

    initial begin
        bus.start = 1'b1;
        bus.op    = MDU_MULT;
        bus.rs    = 32'h5;
        bus.rt    = 32'h7;
        bus.d_md  = 1'b1;
        #1;
        check("rst_stall", bus.stall, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'h0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = MDU_MFHI;
        #1;
        check("rst_rd", bus.rd_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("t1_hi", bus.hi, 32'hFFFF_FFFF);
        check("t1_lo", bus.lo, 32'hFFFF_FFFA);
        run_op(MDU_DIVU, 32'd100, 32'd7, 1'b0);
        check("t2_divu", {bus.hi, bus.lo}, {32'd2, 32'd14});
        run_op(MDU_DIV, -32'sd7, 32'd2, 1'b0);
        check("t2_div", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(MDU_MULT, 32'd1000, 32'd1000, 1'b1);
        check("t3_lo", bus.rd_data, 32'd1000000);
        run_op(MDU_MTHI, 32'h1234_5678, 32'h0, 1'b0);
        check("t4_mthi", bus.hi, 32'h1234_5678);
        run_op(MDU_DIV, 32'd55, 32'd0, 1'b0);
        check("t4_div0", {bus.hi, bus.lo}, {32'h1234_5678, 32'd1000000});
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf", {bus.hi, bus.lo}, {32'h0, 32'h8000_0000});
`ifdef MDU_MADD_EN
        run_op(MDU_MTHI, 32'd0, 32'd0, 1'b0);
        run_op(MDU_MTLO, 32'd5, 32'd0, 1'b0);
        run_op(MDU_MADD, 32'd2, 32'd3, 1'b0);
        check("t6_madd", {bus.hi, bus.lo}, {32'd0, 32'd11});
`endif
        for (int k = 0; k < 80; k++)
            run_op(4'($urandom_range(0, 12)), rnd_val(), rnd_val(), 1'b0);

        run_op(MDU_MTHI, 32'hCAFE_0001, 32'h0, 1'b0);
        run_op(MDU_MTLO, 32'hBEEF_0002, 32'h0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MDU_DIV;
        bus.rs    = 32'd1000;
        bus.rt    = 32'd3;
        repeat (3) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #1;
        check("pre_rst_busy", bus.busy, 1'b1);
        rst_n    = 1'b0;
        bus.d_md = 1'b1;
        bus.op   = MDU_MFHI;
        #1;
        check("t5_busy", bus.busy, 1'b0);
        check("t5_hilo", {bus.hi, bus.lo}, 64'h0);
        check("t5_stall", bus.stall, 1'b0);
        check("t5_rd", bus.rd_data, 32'h0);
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        check("t5_nocommit", {bus.hi, bus.lo}, 64'h0);
        check("t5_idle", bus.busy, 1'b0);
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
